// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port memory between instruction fetch and load/store,
// holding each access stable toward memory until mem_ack and returning data to its owner.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    // state    | meaning
    // IDLE     | no access outstanding; arbitrate whenever a request is high
    // SERVE_IF | fetch access presented to memory, waiting for mem_ack
    // SERVE_D  | load/store access presented to memory, waiting for mem_ack
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SERVE_IF = 2'd1,
        SERVE_D  = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state;
    logic [3:0] starve_cnt;
    logic       fetch_wins;

    // Data has priority unless fetch has watched LIMIT data grants go by.
    assign fetch_wins = !d_req || (if_req && (starve_cnt == LIMIT));
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_ready   <= 1'b0;
            d_ready    <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        mem_req <= 1'b1;
                        if (fetch_wins) begin
                            state      <= SERVE_IF;
                            mem_addr   <= if_addr;
                            mem_we     <= 1'b0;
                            starve_cnt <= 4'd0;
                        end else begin
                            state     <= SERVE_D;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_we    <= d_we;
                            if (!if_req)
                                starve_cnt <= 4'd0;
                            else if (starve_cnt != LIMIT)
                                starve_cnt <= starve_cnt + 4'd1;
                        end
                    end
                end
                SERVE_IF: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        state    <= IDLE;
                        if_ready <= 1'b1;
                        if_rdata <= mem_rdata;
                    end
                end
                SERVE_D: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                        d_ready <= 1'b1;
                        if (!mem_we)
                            d_rdata <= mem_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vectors, corner sequences,
// then random traffic against a transaction-level arbitration and memory model.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ready;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ready;
    logic [DW-1:0] d_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_fetch;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          hold;      // cycles mem_req is high before the ack edge
        logic [31:0] exp_if;
        logic [31:0] exp_d;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req"},   32'(mem_req),  32'd0);
        check({tag, "_mem_we"},    32'(mem_we),   32'd0);
        check({tag, "_if_ready"},  32'(if_ready), 32'd0);
        check({tag, "_d_ready"},   32'(d_ready),  32'd0);
        check({tag, "_busy"},      32'(busy),     32'd0);
        check({tag, "_mem_addr"},  mem_addr,      32'd0);
        check({tag, "_mem_wdata"}, mem_wdata,     32'd0);
        check({tag, "_if_rdata"},  if_rdata,      32'd0);
        check({tag, "_d_rdata"},   d_rdata,       32'd0);
    endtask

    // Waits (bounded) for the negedge at which mem_req is first seen high.
    task automatic wait_grant(input string tag, output bit got);
        got = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (mem_req) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check({tag, "_grant_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit    got;
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge clk);
        if (v.is_fetch) begin
            if_req  = 1'b1;
            if_addr = v.addr;
        end else begin
            d_req   = 1'b1;
            d_we    = v.we;
            d_addr  = v.addr;
            d_wdata = v.wdata;
        end
        wait_grant(tag, got);
        if (got) begin
            check({tag, "_addr"}, mem_addr, v.addr);
            check({tag, "_we"}, 32'(mem_we), 32'(v.is_fetch ? 1'b0 : v.we));
            check({tag, "_busy"}, 32'(busy), 32'd1);
            if (!v.is_fetch && v.we) check({tag, "_wdata"}, mem_wdata, v.wdata);
            for (int i = 1; i < v.hold; i++) begin
                @(negedge clk);
                check({tag, "_hold_req"}, 32'(mem_req), 32'd1);
                check({tag, "_hold_addr"}, mem_addr, v.addr);
                if (!v.is_fetch && v.we) check({tag, "_hold_wdata"}, mem_wdata, v.wdata);
                check({tag, "_hold_noready"}, {30'd0, if_ready, d_ready}, 32'd0);
            end
            mem_ack   = 1'b1;
            mem_rdata = v.rdata;
            @(negedge clk);
            check({tag, "_if_ready"}, 32'(if_ready), 32'(v.is_fetch));
            check({tag, "_d_ready"}, 32'(d_ready), 32'(!v.is_fetch));
            check({tag, "_if_rdata"}, if_rdata, v.exp_if);
            check({tag, "_d_rdata"}, d_rdata, v.exp_d);
            check({tag, "_req_drop"}, 32'(mem_req), 32'd0);
        end
        mem_ack   = 1'b0;
        mem_rdata = '0;
        if_req    = 1'b0;
        d_req     = 1'b0;
        @(negedge clk);
        check({tag, "_pulse_end"}, {30'd0, if_ready, d_ready}, 32'd0);
    endtask

    // random-phase state
    logic [31:0] mem_arr[16];
    bit          txn_act, ack_sent, owner_if, g_we, idle_edge, fetch_win, got;
    logic [31:0] g_addr, g_wdata, exp_rd, last_load, exp_addr;
    int          ack_wait, d_streak;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h40,  32'h0,        32'h8C010004, 1, 32'h8C010004, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 32'h200, 32'h0,        32'h12345678, 2, 32'h8C010004, 32'h12345678};
        vecs[2] = '{1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 32'h5A5A5A5A, 3, 32'h8C010004, 32'h12345678};
        vecs[3] = '{1'b1, 1'b0, 32'h44,  32'h0,        32'h20420001, 2, 32'h20420001, 32'h12345678};
        vecs[4] = '{1'b0, 1'b0, 32'h104, 32'h0,        32'h0BADF00D, 1, 32'h20420001, 32'h0BADF00D};

        #2;
        check_all_zero("por");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // stray ack while idle
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stray_ready", {30'd0, if_ready, d_ready}, 32'd0);
            check("stray_busy", 32'(busy), 32'd0);
            check("stray_if_rdata", if_rdata, 32'h20420001);
            check("stray_d_rdata", d_rdata, 32'h0BADF00D);
        end
        mem_ack   = 1'b0;
        mem_rdata = '0;

        // asynchronous reset pulse mid-cycle
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_all_zero("rst_pulse");
        @(negedge clk);
        reset = 1'b0;

        // reset while a store is outstanding, then a late ack
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h180; d_wdata = 32'hCAFEF00D;
        wait_grant("rst_op", got);
        @(negedge clk);
        check("rst_op_busy_before", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        d_req = 1'b0;
        #1;
        check("rst_op_mem_req", 32'(mem_req), 32'd0);
        check("rst_op_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset   = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("rst_op_no_dready", 32'(d_ready), 32'd0);
        check("rst_op_idle", 32'(busy), 32'd0);
        check("rst_op_req_low", 32'(mem_req), 32'd0);
        @(negedge clk);
        check("rst_op_no_dready2", 32'(d_ready), 32'd0);
        run_vec('{1'b1, 1'b0, 32'h60, 32'h0, 32'h11112222, 1, 32'h11112222, 32'h0}, 5);

        // contention: both requests held, one-cycle ack
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h80;
        d_req  = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        for (int g = 0; g < 10; g++) begin
            wait_grant($sformatf("cont%0d", g), got);
            if (!got) break;
            exp_addr = ((g % (LIM + 1)) == LIM) ? 32'h80 : 32'h300;
            check($sformatf("cont_grant%0d", g), mem_addr, exp_addr);
            mem_ack   = 1'b1;
            mem_rdata = 32'(g);
            @(negedge clk);
            mem_ack = 1'b0;
            check($sformatf("cont_owner%0d", g), {30'd0, if_ready, d_ready},
                  (exp_addr == 32'h80) ? 32'd2 : 32'd1);
        end
        if_req = 1'b0;
        d_req  = 1'b0;

        // randomized traffic against the reference model
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) mem_arr[i] = $urandom;
        txn_act = 0; ack_sent = 0; d_streak = 0; last_load = '0; ack_wait = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            idle_edge = !txn_act;
            if (ack_sent) begin
                ack_sent = 0;
                check("rnd_if_ready", 32'(if_ready), 32'(owner_if));
                check("rnd_d_ready", 32'(d_ready), 32'(!owner_if));
                check("rnd_req_drop", 32'(mem_req), 32'd0);
                if (owner_if) begin
                    check("rnd_if_rdata", if_rdata, exp_rd);
                    if (cyc < 2900 && $urandom_range(0, 1) == 1) if_addr = $urandom;
                    else if_req = 1'b0;
                end else begin
                    if (!g_we) last_load = exp_rd;
                    check("rnd_d_rdata", d_rdata, last_load);
                    if (cyc < 2900 && $urandom_range(0, 1) == 1) begin
                        d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
                    end else d_req = 1'b0;
                end
                txn_act = 0;
            end else begin
                check("rnd_no_ready", {30'd0, if_ready, d_ready}, 32'd0);
            end
            mem_ack   = 1'b0;
            mem_rdata = '0;
            if (idle_edge) begin
                check("rnd_grant", 32'(mem_req), 32'(if_req || d_req));
                if (mem_req && (if_req || d_req)) begin
                    fetch_win = if_req && (!d_req || d_streak >= LIM);
                    if (fetch_win || !if_req) d_streak = 0;
                    else d_streak = d_streak + 1;
                    owner_if = fetch_win;
                    g_addr   = fetch_win ? if_addr : d_addr;
                    g_we     = fetch_win ? 1'b0 : d_we;
                    g_wdata  = d_wdata;
                    check("rnd_grant_addr", mem_addr, g_addr);
                    check("rnd_grant_we", 32'(mem_we), 32'(g_we));
                    txn_act  = 1;
                    ack_wait = $urandom_range(0, 3);
                end
            end
            check("rnd_busy", 32'(busy), 32'(txn_act));
            if (txn_act) begin
                check("rnd_hold_req", 32'(mem_req), 32'd1);
                check("rnd_hold_addr", mem_addr, g_addr);
                if (g_we) check("rnd_hold_wdata", mem_wdata, g_wdata);
                if (ack_wait == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_arr[mem_addr[5:2]];
                    exp_rd    = mem_arr[g_addr[5:2]];
                    if (mem_we) mem_arr[mem_addr[5:2]] = mem_wdata;
                    ack_sent  = 1;
                end else ack_wait--;
            end else if ($urandom_range(0, 3) == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hFFFFFFFF;
            end
            if (cyc < 2900) begin
                if (!if_req && $urandom_range(0, 2) == 0) begin
                    if_req = 1'b1; if_addr = $urandom;
                end
                if (!d_req && $urandom_range(0, 2) == 0) begin
                    d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
                    d_addr = $urandom; d_wdata = $urandom;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
